// File: rtl/load_store_unit.sv
// load_store_unit
//    RV32I load/store unit. It takes one core request at a time, checks
//    funct3 and alignment, and issues a single word-aligned memory access
//    with byte-lane strobes. It waits for the read data or the store ack
//    (with a timeout), then returns one response pulse carrying the
//    extended load data.
//
//    Ports
//       clk, rst_n        clock (rising edge); synchronous active-low reset
//       req_*             core request channel (valid/ready handshake)
//       mem_req/we/addr   memory request, held stable until mem_gnt
//       mem_wstrb/wdata   byte-lane enables and lane-positioned store data
//       mem_gnt           memory accepted the request
//       mem_rvalid/rdata  read data valid (or store ack) and read word
//       rsp_*             one-cycle result pulse; data, rd and err hold between pulses
//       busy              unit is not idle
module load_store_unit #(
   parameter int BIT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [BIT_WIDTH-1:0] req_addr,
   input  logic [BIT_WIDTH-1:0] req_wdata,
   input  logic [4:0]           req_rd,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [BIT_WIDTH-1:0] mem_addr,
   output logic [3:0]           mem_wstrb,
   output logic [BIT_WIDTH-1:0] mem_wdata,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [BIT_WIDTH-1:0] mem_rdata,
   output logic                 rsp_valid,
   output logic [BIT_WIDTH-1:0] rsp_rdata,
   output logic [4:0]           rsp_rd,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [2:0]             funct3_q, funct3_d;
   logic [1:0]             addr_lo_q, addr_lo_d;
   logic [4:0]             rd_q, rd_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [BIT_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]             mem_wstrb_q, mem_wstrb_d;
   logic [BIT_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [BIT_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [4:0]             rsp_rd_q, rsp_rd_d;
   logic                   rsp_err_q, rsp_err_d;

   logic                   accept_s;
   logic                   legal_s;
   logic                   misal_s;
   logic                   bad_s;
   logic                   timeout_s;
   logic [3:0]             strb_s;
   logic [BIT_WIDTH-1:0]   wdata_s;
   logic [BIT_WIDTH-1:0]   lane_s;
   logic [BIT_WIDTH-1:0]   ext_s;

   assign accept_s  = req_valid && (state_q == S_IDLE);
   assign timeout_s = (cnt_q == CW'(TIMEOUT_CYCLES));
   assign bad_s     = !legal_s || misal_s;

   // Request decode: funct3 legality, alignment and store lane placement.
   always_comb begin
      legal_s = 1'b0;
      misal_s = 1'b0;
      strb_s  = 4'b0000;
      wdata_s = {BIT_WIDTH{1'b0}};
      case (req_funct3)
         3'b000: begin
            legal_s = 1'b1;
            strb_s  = 4'b0001 << req_addr[1:0];
            wdata_s = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            legal_s = 1'b1;
            misal_s = req_addr[0];
            strb_s  = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{req_wdata[15:0]}};
         end
         3'b010: begin
            legal_s = 1'b1;
            misal_s = (req_addr[1:0] != 2'b00);
            strb_s  = 4'b1111;
            wdata_s = req_wdata;
         end
         3'b100, 3'b101: begin
            // unsigned forms exist only for loads; halfword still needs alignment
            legal_s = !req_we;
            misal_s = req_funct3[0] && req_addr[0];
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
      if (!req_we) begin
         strb_s  = 4'b0000;
         wdata_s = {BIT_WIDTH{1'b0}};
      end else begin
         strb_s  = strb_s;
      end
   end

   // Load lane extraction and sign/zero extension from the latched size code.
   always_comb begin
      lane_s = mem_rdata >> {addr_lo_q, 3'b000};
      case (funct3_q)
         3'b000:  ext_s = {{24{lane_s[7]}}, lane_s[7:0]};
         3'b001:  ext_s = {{16{lane_s[15]}}, lane_s[15:0]};
         3'b100:  ext_s = {24'h000000, lane_s[7:0]};
         3'b101:  ext_s = {16'h0000, lane_s[15:0]};
         default: ext_s = lane_s;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = bad_s ? S_RESP : S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (mem_rvalid || timeout_s) begin
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values; everything holds unless updated here.
   always_comb begin
      cnt_d       = cnt_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      rd_d        = rd_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               we_d      = req_we;
               funct3_d  = req_funct3;
               addr_lo_d = req_addr[1:0];
               rd_d      = req_rd;
               if (bad_s) begin
                  // rejected before any memory access is issued
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = {BIT_WIDTH{1'b0}};
                  rsp_rd_d    = req_we ? 5'd0 : req_rd;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[BIT_WIDTH-1:2], 2'b00};
                  mem_wstrb_d = strb_s;
                  mem_wdata_d = wdata_s;
               end
            end else begin
               mem_req_d = 1'b0;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               cnt_d     = {CW{1'b0}};
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (mem_rvalid) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = we_q ? {BIT_WIDTH{1'b0}} : ext_s;
               rsp_rd_d    = we_q ? 5'd0 : rd_q;
            end else if (timeout_s) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = {BIT_WIDTH{1'b0}};
               rsp_rd_d    = we_q ? 5'd0 : rd_q;
            end else begin
               rsp_valid_d = 1'b0;
            end
         end
         S_RESP: begin
            rsp_valid_d = 1'b0;
         end
         default: begin
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CW{1'b0}};
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_lo_q   <= 2'b00;
         rd_q        <= 5'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {BIT_WIDTH{1'b0}};
         mem_wstrb_q <= 4'b0000;
         mem_wdata_q <= {BIT_WIDTH{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {BIT_WIDTH{1'b0}};
         rsp_rd_q    <= 5'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         rd_q        <= rd_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        busy;

   load_store_unit #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic [4:0]  e_rd;
   } vec_t;

   localparam int NV = 14;
   vec_t vec [NV];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
         n_err++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!req_ready && k < 20) begin
         step();
         k++;
      end
      chk("wait_ready", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      wait_ready();
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_rd     = rd;
      step();
      req_valid  = 1'b0;
   endtask

   initial begin
      //          we    f3      addr          wdata         rd     rdata         err   e_addr        e_strb   e_wdata       e_rdata       e_rd
      vec[0]  = '{1'b0, 3'b000, 32'h00000103, 32'h00000000, 5'd5,  32'h80000000, 1'b0, 32'h00000100, 4'b0000, 32'h00000000, 32'hFFFFFF80, 5'd5};
      vec[1]  = '{1'b0, 3'b101, 32'h00000202, 32'h00000000, 5'd6,  32'hBEEF1234, 1'b0, 32'h00000200, 4'b0000, 32'h00000000, 32'h0000BEEF, 5'd6};
      vec[2]  = '{1'b0, 3'b001, 32'h00000202, 32'h00000000, 5'd7,  32'hBEEF1234, 1'b0, 32'h00000200, 4'b0000, 32'h00000000, 32'hFFFFBEEF, 5'd7};
      vec[3]  = '{1'b1, 3'b000, 32'h00000101, 32'h000000A5, 5'd7,  32'h00000000, 1'b0, 32'h00000100, 4'b0010, 32'hA5A5A5A5, 32'h00000000, 5'd0};
      vec[4]  = '{1'b0, 3'b010, 32'h00000102, 32'h00000000, 5'd1,  32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 5'd0};
      vec[5]  = '{1'b0, 3'b011, 32'h00000100, 32'h00000000, 5'd2,  32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 5'd0};
      vec[6]  = '{1'b0, 3'b010, 32'h00000200, 32'h00000000, 5'd9,  32'h12345678, 1'b0, 32'h00000200, 4'b0000, 32'h00000000, 32'h12345678, 5'd9};
      vec[7]  = '{1'b0, 3'b100, 32'h00000301, 32'h00000000, 5'd10, 32'h00009A00, 1'b0, 32'h00000300, 4'b0000, 32'h00000000, 32'h0000009A, 5'd10};
      vec[8]  = '{1'b1, 3'b001, 32'h00000206, 32'h0000CAFE, 5'd3,  32'h00000000, 1'b0, 32'h00000204, 4'b1100, 32'hCAFECAFE, 32'h00000000, 5'd0};
      vec[9]  = '{1'b1, 3'b010, 32'h0000040C, 32'hDEADBEEF, 5'd4,  32'h00000000, 1'b0, 32'h0000040C, 4'b1111, 32'hDEADBEEF, 32'h00000000, 5'd0};
      vec[10] = '{1'b1, 3'b001, 32'h00000201, 32'h00001111, 5'd0,  32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 5'd0};
      vec[11] = '{1'b1, 3'b100, 32'h00000200, 32'h00001111, 5'd0,  32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 5'd0};
      vec[12] = '{1'b0, 3'b001, 32'h00000300, 32'h00000000, 5'd11, 32'h00007FFF, 1'b0, 32'h00000300, 4'b0000, 32'h00000000, 32'h00007FFF, 5'd11};
      vec[13] = '{1'b0, 3'b000, 32'h00000100, 32'h00000000, 5'd12, 32'h000000FF, 1'b0, 32'h00000100, 4'b0000, 32'h00000000, 32'hFFFFFFFF, 5'd12};

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      step();
      step();
      // reset state
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_mem_addr",  mem_addr,           32'h0);
      chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
      chk("rst_mem_wdata", mem_wdata,          32'h0);
      chk("rst_rsp_rdata", rsp_rdata,          32'h0);
      chk("rst_rsp_rd",    {27'd0, rsp_rd},    32'h0);
      rst_n = 1'b1;
      step();

      // table-driven single accesses with immediate gnt and rvalid
      for (int i = 0; i < NV; i++) begin
         issue(vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata, vec[i].rd);
         if (vec[i].err) begin
            chk($sformatf("v%0d_err_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("v%0d_err_flag", i),  {31'd0, rsp_err},   32'd1);
            chk($sformatf("v%0d_err_nomem", i), {31'd0, mem_req},   32'd0);
            chk($sformatf("v%0d_err_rdata", i), rsp_rdata,          32'h0);
            step();
            chk($sformatf("v%0d_err_pulse", i), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("v%0d_err_idle", i),  {31'd0, req_ready}, 32'd1);
         end else begin
            chk($sformatf("v%0d_mem_req", i),  {31'd0, mem_req},   32'd1);
            chk($sformatf("v%0d_mem_we", i),   {31'd0, mem_we},    {31'd0, vec[i].we});
            chk($sformatf("v%0d_mem_addr", i), mem_addr,           vec[i].e_addr);
            chk($sformatf("v%0d_wstrb", i),    {28'd0, mem_wstrb}, {28'd0, vec[i].e_strb});
            if (vec[i].we) begin
               chk($sformatf("v%0d_wdata", i), mem_wdata, vec[i].e_wdata);
            end
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            chk($sformatf("v%0d_req_drop", i), {31'd0, mem_req},   32'd0);
            chk($sformatf("v%0d_no_early", i), {31'd0, rsp_valid}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = vec[i].rdata;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A5A5A;
            chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata,          vec[i].e_rdata);
            chk($sformatf("v%0d_rsp_err", i),   {31'd0, rsp_err},   32'd0);
            chk($sformatf("v%0d_rsp_rd", i),    {27'd0, rsp_rd},    {27'd0, vec[i].e_rd});
            step();
            chk($sformatf("v%0d_pulse", i),     {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("v%0d_hold", i),      rsp_rdata,          vec[i].e_rdata);
            chk($sformatf("v%0d_ready", i),     {31'd0, req_ready}, 32'd1);
         end
      end

      // delayed grant: request held stable, stray rvalid before grant ignored
      issue(1'b0, 3'b010, 32'h00000500, 32'h0, 5'd13);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("dly%0d_mem_req", k),  {31'd0, mem_req},   32'd1);
         chk($sformatf("dly%0d_mem_addr", k), mem_addr,           32'h00000500);
         chk($sformatf("dly%0d_no_rsp", k),   {31'd0, rsp_valid}, 32'd0);
         mem_rvalid = (k == 2);
         mem_rdata  = 32'h11111111;
         step();
         mem_rvalid = 1'b0;
      end
      chk("dly_still_req", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("dly_wait%0d", k), {31'd0, rsp_valid}, 32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      chk("dly_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("dly_rsp_rdata", rsp_rdata,          32'hCAFEF00D);
      chk("dly_rsp_rd",    {27'd0, rsp_rd},    32'd13);
      step();

      // timeout: grant, then no rvalid
      begin
         int cyc;
         issue(1'b0, 3'b010, 32'h00000600, 32'h0, 5'd14);
         mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
         cyc = 0;
         while (!rsp_valid && cyc < 400) begin
            step();
            cyc++;
         end
         chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("to_rsp_err",   {31'd0, rsp_err},   32'd1);
         chk("to_rsp_rdata", rsp_rdata,          32'h0);
         chk("to_min_wait",  {31'd0, (cyc >= 255)}, 32'd1);
         chk("to_max_wait",  {31'd0, (cyc <= 257)}, 32'd1);
         step();
         chk("to_pulse",     {31'd0, rsp_valid}, 32'd0);
         chk("to_err_hold",  {31'd0, rsp_err},   32'd1);
      end

      // reset while waiting, then a late rvalid
      issue(1'b0, 3'b010, 32'h00000700, 32'h0, 5'd15);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      step();
      chk("rw_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h77777777;
      step();
      mem_rvalid = 1'b0;
      chk("rw_no_rsp",   {31'd0, rsp_valid}, 32'd0);
      chk("rw_ready",    {31'd0, req_ready}, 32'd1);
      chk("rw_idle",     {31'd0, busy},      32'd0);
      chk("rw_no_req",   {31'd0, mem_req},   32'd0);
      step();
      chk("rw_no_rsp2",  {31'd0, rsp_valid}, 32'd0);
      chk("rw_rdata",    rsp_rdata,          32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be (one per line):
  BIT_WIDTH, 32, data/address width; only 32 supported
  TIMEOUT_CYCLES, 255, max WAIT-state cycles before error
REQ-002 Ports SHALL be (one per line: name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  synchronous, active-low reset
  req_valid  in  1  core access request
  req_ready  out  1  unit can accept request
  req_we  in  1  1=store, 0=load
  req_funct3  in  3  RV32I size/sign code
  req_addr  in  32  byte address
  req_wdata  in  32  store data, LSB-aligned
  req_rd  in  5  load destination register
  mem_req  out  1  memory request
  mem_we  out  1  memory write enable
  mem_addr  out  32  word address (bits[1:0]=0)
  mem_wstrb  out  4  byte-lane enables
  mem_wdata  out  32  lane-positioned store data
  mem_gnt  in  1  memory accepted request
  mem_rvalid  in  1  read data valid / store ack
  mem_rdata  in  32  read word
  rsp_valid  out  1  result valid, one cycle
  rsp_rdata  out  32  extended load data, feeds writeback select mux
  rsp_rd  out  5  destination register of result
  rsp_err  out  1  misaligned, illegal funct3, or timeout
  busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-004 Accept = req_valid & req_ready at edge N: latch we, funct3, addr, wdata, rd; next state REQ, or RESP with rsp_err=1 if illegal/misaligned.
REQ-005 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; all others illegal.
REQ-006 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0; no memory access issued.
REQ-007 REQ: mem_req=1, outputs held stable until mem_gnt=1; on gnt -> WAIT, timeout counter cleared.
REQ-008 WAIT: mem_req=0; mem_rvalid=1 -> RESP; mem_rvalid ignored outside WAIT.
REQ-009 WAIT: counter increments each cycle; counter==TIMEOUT_CYCLES without rvalid -> RESP, rsp_err=1, rsp_rdata=0.
REQ-010 RESP: rsp_valid=1 exactly one cycle, then IDLE; new request accepted no earlier than following cycle.
REQ-011 mem_addr = {addr[31:2],2'b00}; mem_we=latched we.
REQ-012 SB: wstrb=1<<addr[1:0], wdata=byte replicated x4; SH: wstrb=0011 (addr[1]=0) or 1100, wdata=half replicated x2; SW: 1111, wdata unchanged; loads: wstrb=0000.
REQ-013 Load lane = mem_rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; captured on the rvalid cycle.
REQ-014 Stores: rsp_rdata=0; rsp_rd=0; rsp_valid still pulsed on ack.
REQ-015 Latency: accept at N, gnt at N+1, rvalid at N+2 -> rsp_valid at N+3 (minimum); error-on-accept -> rsp_valid at N+1.
REQ-016 rsp_rdata/rsp_rd/rsp_err SHALL hold last value when rsp_valid=0.

Reset
REQ-017 rst_n=0 at an edge: state IDLE, counter 0; mem_req, mem_we, rsp_valid, rsp_err=0; mem_addr, mem_wstrb, mem_wdata, rsp_rdata, rsp_rd=0; req_ready=1 after the reset edge.
REQ-018 Reset in any state aborts the access; late mem_gnt/mem_rvalid afterwards ignored.

Verification
REQ-019 LB addr 0x103, mem_rdata 0x80_00_00_00, gnt+rvalid immediate -> rsp_rdata 0xFFFFFF80, rsp_valid at N+3.
REQ-020 LHU addr 0x202, rdata 0xBEEF1234 -> rsp_rdata 0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-021 SB addr 0x101, wdata 0x000000A5 -> mem_addr 0x100, wstrb 0010, mem_wdata 0xA5A5A5A5, rsp_rdata 0.
REQ-022 LW addr 0x102 -> no mem_req, rsp_valid+rsp_err at N+1; funct3 011 -> same.
REQ-023 gnt held low 5 cycles -> mem_req and outputs stable 5 cycles; no rvalid for 255 WAIT cycles -> rsp_err=1, rsp_rdata 0.
REQ-024 rst_n=0 in WAIT, then rvalid pulse -> no rsp_valid, IDLE, req_ready=1.
